// File: rtl/sap1_pkg.sv
// Shared types for the SAP-1 control sequencer: opcodes, T-state encoding
// and the packed control word.
package sap1_pkg;

  localparam int OPC_W = 4;
  localparam int NUM_T = 6;

  typedef enum logic [OPC_W-1:0] {
    OP_LDA = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_OUT = 4'b1110,
    OP_HLT = 4'b1111
  } opcode_e;

  typedef enum logic [NUM_T-1:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  typedef struct packed {
    logic pc_inc;
    logic pc_en;
    logic mar_load;
    logic ram_en;
    logic ir_load;
    logic ir_en;
    logic a_load;
    logic a_en;
    logic alu_sub;
    logic alu_en;
    logic b_load;
    logic out_load;
  } ctrl_word_t;

endpackage

// File: rtl/sap1_ring_counter.sv
// Six-state one-hot T-state ring; rotates one position per cycle when adv is high.
module sap1_ring_counter
  import sap1_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  output logic [NUM_T-1:0] t_state
);

  tstate_e state, state_next;

  always_ff @(posedge clk) begin
    if (reset) state <= T1;
    else       state <= state_next;
  end

  // Any non-one-hot value (e.g. after an upset) falls back to T1.
  always_comb begin
    state_next = state;
    if (adv) begin
      case (state)
        T1:      state_next = T2;
        T2:      state_next = T3;
        T3:      state_next = T4;
        T4:      state_next = T5;
        T5:      state_next = T6;
        T6:      state_next = T1;
        default: state_next = T1;
      endcase
    end
  end

  assign t_state = state;

endmodule

// File: rtl/sap1_control_sequencer.sv
// SAP-1 control unit: T-state ring plus (t_state, opcode) decode into the bus
// control word, with run/step advance and a sticky halt.
module sap1_control_sequencer
  import sap1_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic [OPC_W-1:0] opcode,
  output logic [NUM_T-1:0] t_state,
  output logic             pc_inc,
  output logic             pc_en,
  output logic             mar_load,
  output logic             ram_en,
  output logic             ir_load,
  output logic             ir_en,
  output logic             a_load,
  output logic             a_en,
  output logic             alu_sub,
  output logic             alu_en,
  output logic             b_load,
  output logic             out_load,
  output logic             halted
);

  logic       adv;
  logic       halt_now;
  logic       ring_adv;
  ctrl_word_t ctrl;

  // Gating with reset keeps the control word clear during the reset cycle.
  assign adv      = (run | step) & ~halted & ~reset;
  assign halt_now = adv && (t_state == T4) && (opcode == OP_HLT);
  assign ring_adv = adv & ~halt_now;

  sap1_ring_counter u_ring (
    .clk     (clk),
    .reset   (reset),
    .adv     (ring_adv),
    .t_state (t_state)
  );

  always_ff @(posedge clk) begin
    if (reset)         halted <= 1'b0;
    else if (halt_now) halted <= 1'b1;
  end

  always_comb begin
    ctrl = '0;
    if (adv) begin
      case (t_state)
        T1: begin
          ctrl.pc_en    = 1'b1;
          ctrl.mar_load = 1'b1;
        end
        T2: ctrl.pc_inc = 1'b1;
        T3: begin
          ctrl.ram_en  = 1'b1;
          ctrl.ir_load = 1'b1;
        end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              ctrl.ir_en    = 1'b1;
              ctrl.mar_load = 1'b1;
            end
            OP_OUT: begin
              ctrl.a_en     = 1'b1;
              ctrl.out_load = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              ctrl.ram_en = 1'b1;
              ctrl.a_load = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ctrl.ram_en  = 1'b1;
              ctrl.b_load  = 1'b1;
              ctrl.alu_sub = (opcode == OP_SUB);
            end
            default: ;
          endcase
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            ctrl.alu_en  = 1'b1;
            ctrl.a_load  = 1'b1;
            ctrl.alu_sub = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign pc_inc   = ctrl.pc_inc;
  assign pc_en    = ctrl.pc_en;
  assign mar_load = ctrl.mar_load;
  assign ram_en   = ctrl.ram_en;
  assign ir_load  = ctrl.ir_load;
  assign ir_en    = ctrl.ir_en;
  assign a_load   = ctrl.a_load;
  assign a_en     = ctrl.a_en;
  assign alu_sub  = ctrl.alu_sub;
  assign alu_en   = ctrl.alu_en;
  assign b_load   = ctrl.b_load;
  assign out_load = ctrl.out_load;

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Bench for sap1_control_sequencer: a reference model predicts control word,
// t_state and halted each cycle; scenario tasks add targeted checks.
module tb_sap1_control_sequencer;

  localparam int W = 19;
  localparam int PC_INC = 11, PC_EN = 10, MAR_LOAD = 9, RAM_EN = 8, IR_LOAD = 7,
                 IR_EN = 6, A_LOAD = 5, A_EN = 4, ALU_SUB = 3, ALU_EN = 2,
                 B_LOAD = 1, OUT_LOAD = 0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic [5:0] t_state;
  logic pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en;
  logic a_load, a_en, alu_sub, alu_en, b_load, out_load, halted;

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q[$];
  int           m_t = 0;
  logic         m_halted = 1'b0;

  wire [11:0] obs_ctrl = {pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en,
                          a_load, a_en, alu_sub, alu_en, b_load, out_load};

  sap1_control_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .step     (step),
    .opcode   (opcode),
    .t_state  (t_state),
    .pc_inc   (pc_inc),
    .pc_en    (pc_en),
    .mar_load (mar_load),
    .ram_en   (ram_en),
    .ir_load  (ir_load),
    .ir_en    (ir_en),
    .a_load   (a_load),
    .a_en     (a_en),
    .alu_sub  (alu_sub),
    .alu_en   (alu_en),
    .b_load   (b_load),
    .out_load (out_load),
    .halted   (halted)
  );

  // clock
  always #5 clk = ~clk;

  // Reference control word, built straight from the instruction table.
  function automatic logic [11:0] exp_ctrl(input int t, input logic [3:0] op, input logic adv);
    logic [11:0] c;
    c = '0;
    if (adv) begin
      case (t)
        0: begin c[PC_EN] = 1'b1; c[MAR_LOAD] = 1'b1; end
        1: c[PC_INC] = 1'b1;
        2: begin c[RAM_EN] = 1'b1; c[IR_LOAD] = 1'b1; end
        3: begin
          if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin c[IR_EN] = 1'b1; c[MAR_LOAD] = 1'b1; end
          if (op == 4'hE) begin c[A_EN] = 1'b1; c[OUT_LOAD] = 1'b1; end
        end
        4: begin
          if (op == 4'h0) begin c[RAM_EN] = 1'b1; c[A_LOAD] = 1'b1; end
          if (op == 4'h1) begin c[RAM_EN] = 1'b1; c[B_LOAD] = 1'b1; end
          if (op == 4'h2) begin c[RAM_EN] = 1'b1; c[B_LOAD] = 1'b1; c[ALU_SUB] = 1'b1; end
        end
        5: begin
          if (op == 4'h1) begin c[ALU_EN] = 1'b1; c[A_LOAD] = 1'b1; end
          if (op == 4'h2) begin c[ALU_EN] = 1'b1; c[A_LOAD] = 1'b1; c[ALU_SUB] = 1'b1; end
        end
        default: ;
      endcase
    end
    return c;
  endfunction

  // Driver: advance the model on the edge, apply new inputs, queue expectation,
  // return at the following negedge where outputs are stable.
  task automatic drive(input logic r, input logic s, input logic [3:0] op, input logic rst);
    logic adv;
    @(posedge clk);
    adv = (run | step) & ~m_halted;
    if (reset) begin
      m_t = 0;
      m_halted = 1'b0;
    end else if (adv) begin
      if (m_t == 3 && opcode == 4'hF) m_halted = 1'b1;
      else m_t = (m_t + 1) % 6;
    end
    #1;
    run = r; step = s; opcode = op; reset = rst;
    adv = (r | s) & ~m_halted & ~rst;
    exp_q.push_back({exp_ctrl(m_t, op, adv), 6'(6'b000001 << m_t), m_halted});
    @(negedge clk);
  endtask

  // Scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if ({obs_ctrl, t_state, halted} !== e) begin
        tests_failed++;
        $display("FAIL sb t=%0t ctrl/t_state/halted got %h/%b/%b want %h/%b/%b",
                 $time, obs_ctrl, t_state, halted, e[18:7], e[6:1], e[0]);
      end
    end
  end

  task automatic test_reset;
    drive(0, 0, 4'h0, 1);
    drive(1, 1, 4'h0, 1);
    tests_run++;
    if (obs_ctrl !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_ctrl got %h want 000", obs_ctrl);
    end
    drive(0, 0, 4'h0, 0);
    tests_run++;
    if (t_state !== 6'b000001 || halted !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state got t=%b h=%b want 000001/0", t_state, halted);
    end
  endtask

  task automatic test_lda_run;
    drive(0, 0, 4'h0, 1);
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 4'h0, 0);
      tests_run++;
      if (t_state !== 6'(6'b000001 << (i % 6))) begin
        tests_failed++;
        $display("FAIL lda_ring i=%0d got %b", i, t_state);
      end
      if (i % 6 == 0) begin
        tests_run++;
        if ({pc_en, mar_load} !== 2'b11) begin
          tests_failed++;
          $display("FAIL lda_t1 got pc_en=%b mar_load=%b want 1/1", pc_en, mar_load);
        end
      end
      if (i % 6 == 4) begin
        tests_run++;
        if ({ram_en, a_load} !== 2'b11) begin
          tests_failed++;
          $display("FAIL lda_t5 got ram_en=%b a_load=%b want 1/1", ram_en, a_load);
        end
      end
    end
  endtask

  task automatic test_sub;
    drive(0, 0, 4'h2, 1);
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 4'h2, 0);
      if (i == 4) begin
        tests_run++;
        if ({ram_en, b_load, alu_sub, a_load} !== 4'b1110) begin
          tests_failed++;
          $display("FAIL sub_t5 got %b want 1110", {ram_en, b_load, alu_sub, a_load});
        end
      end
      if (i == 5) begin
        tests_run++;
        if ({alu_en, a_load, alu_sub, ram_en} !== 4'b1110) begin
          tests_failed++;
          $display("FAIL sub_t6 got %b want 1110", {alu_en, a_load, alu_sub, ram_en});
        end
      end
    end
  endtask

  task automatic test_step;
    drive(0, 0, 4'h0, 1);
    drive(1, 0, 4'h0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 4'h0, 0);
      tests_run++;
      if (t_state !== 6'b000010 || pc_inc !== 1'b0) begin
        tests_failed++;
        $display("FAIL step_hold got t=%b pc_inc=%b want 000010/0", t_state, pc_inc);
      end
    end
    drive(0, 1, 4'h0, 0);
    tests_run++;
    if (pc_inc !== 1'b1) begin
      tests_failed++;
      $display("FAIL step_pulse got pc_inc=%b want 1", pc_inc);
    end
    drive(0, 0, 4'h0, 0);
    tests_run++;
    if (t_state !== 6'b000100) begin
      tests_failed++;
      $display("FAIL step_next got %b want 000100", t_state);
    end
  endtask

  task automatic test_halt;
    drive(0, 0, 4'hF, 1);
    for (int i = 0; i < 4; i++) drive(1, 0, 4'hF, 0);
    tests_run++;
    if (obs_ctrl !== 12'h000) begin
      tests_failed++;
      $display("FAIL hlt_t4 got %h want 000", obs_ctrl);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'hF, 0);
      tests_run++;
      if (halted !== 1'b1 || t_state !== 6'b001000 || obs_ctrl !== 12'h000) begin
        tests_failed++;
        $display("FAIL halt_hold got h=%b t=%b ctrl=%h want 1/001000/000", halted, t_state, obs_ctrl);
      end
    end
    drive(1, 0, 4'h0, 1);
    drive(0, 0, 4'h0, 0);
    tests_run++;
    if (t_state !== 6'b000001 || halted !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_clear got t=%b h=%b want 000001/0", t_state, halted);
    end
  endtask

  task automatic test_reset_mid;
    drive(0, 0, 4'h1, 1);
    for (int i = 0; i < 4; i++) drive(1, 0, 4'h1, 0);
    drive(1, 0, 4'h1, 1);
    tests_run++;
    if (obs_ctrl !== 12'h000 || t_state !== 6'b010000) begin
      tests_failed++;
      $display("FAIL rst_mid got ctrl=%h t=%b want 000/010000", obs_ctrl, t_state);
    end
    drive(0, 0, 4'h1, 0);
    tests_run++;
    if (t_state !== 6'b000001) begin
      tests_failed++;
      $display("FAIL rst_mid_t1 got %b want 000001", t_state);
    end
  endtask

  task automatic test_random;
    drive(0, 0, 4'h0, 1);
    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            4'($urandom_range(0, 15)), ($urandom_range(0, 39) == 0));
      tests_run++;
      if (!$onehot(t_state) || $countones({pc_en, ram_en, ir_en, a_en, alu_en}) > 1) begin
        tests_failed++;
        $display("FAIL rand_inv i=%0d t=%b drivers=%b", i, t_state,
                 {pc_en, ram_en, ir_en, a_en, alu_en});
      end
    end
  endtask

  initial begin
    test_reset();
    test_lda_run();
    test_sub();
    test_step();
    test_halt();
    test_reset_mid();
    test_random();
    @(posedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain got %0d left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
